// File: rtl/tqvp_prism_cfg_seq_if.sv
// tqvp_prism_cfg_seq_if
//   Bundles every bus-level signal of the PRISM configuration sequencer.
//   The clock and reset stay outside the bundle as plain ports.
//   Modports:
//     master : the environment (software push port, host bus, PRISM read data)
//     slave  : the sequencer itself
//   Signal groups:
//     push_valid/push_ready/push_addr/push_data   config FIFO enqueue
//     start/abort                                 sequence control pulses
//     host_wr/host_addr/host_wdata/host_grant     host pass-through bus
//     dbg_wr/dbg_addr/dbg_wdata/dbg_rdata         PRISM debug port
//     prism_reset/prism_enable                    PRISM control
//     busy/done/err/fill                          status
interface tqvp_prism_cfg_seq_if #(
    parameter int DEPTH = 8
);
    logic                         push_valid;
    logic                         push_ready;
    logic [5:0]                   push_addr;
    logic [31:0]                  push_data;
    logic                         start;
    logic                         abort;
    logic                         host_wr;
    logic [5:0]                   host_addr;
    logic [31:0]                  host_wdata;
    logic                         host_grant;
    logic                         dbg_wr;
    logic [5:0]                   dbg_addr;
    logic [31:0]                  dbg_wdata;
    logic [31:0]                  dbg_rdata;
    logic                         prism_reset;
    logic                         prism_enable;
    logic                         busy;
    logic                         done;
    logic                         err;
    logic [$clog2(DEPTH+1)-1:0]   fill;

    modport master (
        output push_valid, push_addr, push_data, start, abort,
               host_wr, host_addr, host_wdata, dbg_rdata,
        input  push_ready, host_grant, dbg_wr, dbg_addr, dbg_wdata,
               prism_reset, prism_enable, busy, done, err, fill
    );

    modport slave (
        input  push_valid, push_addr, push_data, start, abort,
               host_wr, host_addr, host_wdata, dbg_rdata,
        output push_ready, host_grant, dbg_wr, dbg_addr, dbg_wdata,
               prism_reset, prism_enable, busy, done, err, fill
    );
endinterface

// File: rtl/tqvp_prism_cfg_seq.sv
// tqvp_prism_cfg_seq
//   Configuration sequencer and debug-port arbiter for the PRISM controller.
//   Software queues (addr,data) writes into a small FIFO. A start pulse holds
//   PRISM in reset, plays the queue out on the debug port with idle spacing,
//   then releases PRISM with fsm_enable set. While idle, host writes pass
//   straight through to the debug port.
//   Ports:
//     clk   clock
//     rst   synchronous, active-high reset
//     bus   tqvp_prism_cfg_seq_if.slave (push port, control, host bus,
//           debug port, PRISM control, status)
//   Parameters: DEPTH (FIFO entries, power of 2, >=2), SETTLE (reset hold
//   cycles before the first write, >=1), GAP (idle cycles after each write, >=1).
//   Build option: define PRISM_CFG_READBACK_EN to read back each written
//   register on the first gap cycle; a mismatch takes the abort path.
module tqvp_prism_cfg_seq #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 4,
    parameter int GAP    = 2
) (
    input logic                 clk,
    input logic                 rst,
    tqvp_prism_cfg_seq_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = $clog2(DEPTH + 1);
    localparam int CMAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_WRITE,
        S_GAP,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;

    logic [5:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FW-1:0] fill_q;

    logic prism_reset_q, prism_enable_q, done_q, err_q;
    logic idle, start_go, abort_run, flush, push_ok, pop, rb_fail;

    assign idle     = (state_q == S_IDLE);
    // Abort outranks a same-cycle start.
    assign start_go = idle && bus.start && !bus.abort;

`ifdef PRISM_CFG_READBACK_EN
    logic [5:0]  last_addr_q;
    logic [31:0] last_data_q;

    // First gap cycle: the debug port shows the just-written address and the
    // returned data must match what was written.
    assign rb_fail = (state_q == S_GAP) && (cnt_q == '0) && (bus.dbg_rdata != last_data_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q <= '0;
            last_data_q <= '0;
        end else if (state_q == S_WRITE) begin
            last_addr_q <= mem_addr[rd_ptr_q];
            last_data_q <= mem_data[rd_ptr_q];
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.dbg_rdata;
    assign rb_fail      = 1'b0;
`endif

    // A readback miss can only occur while running, so it never fires in IDLE.
    assign abort_run = !idle && (bus.abort || rb_fail);
    assign flush     = bus.abort || rb_fail;
    assign push_ok   = bus.push_valid && bus.push_ready && !flush;
    assign pop       = (state_q == S_WRITE) && !flush;

    // NOTE: the storage array has no reset; fill guarantees a slot is written before it is read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr_q] <= bus.push_addr;
            mem_data[wr_ptr_q] <= bus.push_data;
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every state change; it times RESET and GAP.
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d       = state_q;
        bus.dbg_wr    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        case (state_q)
            S_IDLE: begin
                bus.dbg_wr    = bus.host_wr;
                bus.dbg_addr  = bus.host_addr;
                bus.dbg_wdata = bus.host_wdata;
                if (start_go && fill_q != '0) state_d = S_RESET;
            end
            S_RESET: begin
                if (cnt_q == CW'(SETTLE - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                bus.dbg_wr    = 1'b1;
                bus.dbg_addr  = mem_addr[rd_ptr_q];
                bus.dbg_wdata = mem_data[rd_ptr_q];
                state_d       = S_GAP;
            end
            S_GAP: begin
`ifdef PRISM_CFG_READBACK_EN
                if (cnt_q == '0) bus.dbg_addr = last_addr_q;
`endif
                if (cnt_q == CW'(GAP - 1)) state_d = (fill_q != '0) ? S_WRITE : S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_run) state_d = S_IDLE;
    end

    // PRISM control is registered: it must persist in IDLE after a run or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            prism_reset_q  <= 1'b0;
            prism_enable_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_run) begin
                prism_reset_q  <= 1'b1;
                prism_enable_q <= 1'b0;
                err_q          <= 1'b1;
            end else if (start_go) begin
                err_q <= 1'b0;
                if (fill_q == '0) begin
                    done_q <= 1'b1;
                end else begin
                    prism_reset_q  <= 1'b1;
                    prism_enable_q <= 1'b0;
                end
            end else begin
                if (state_d == S_RELEASE) begin
                    prism_reset_q  <= 1'b0;
                    prism_enable_q <= 1'b1;
                end
                if (state_q == S_RELEASE) done_q <= 1'b1;
            end
        end
    end

    assign bus.push_ready   = (fill_q != FW'(DEPTH));
    assign bus.fill         = fill_q;
    assign bus.host_grant   = idle;
    assign bus.busy         = !idle;
    assign bus.prism_reset  = prism_reset_q;
    assign bus.prism_enable = prism_enable_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_tqvp_prism_cfg_seq.sv
// tb_tqvp_prism_cfg_seq
//   Self-checking bench for tqvp_prism_cfg_seq. A queue-based model tracks
//   the FIFO and the position inside a run as a cycle offset from start;
//   a compare process checks every output on every cycle. Directed
//   scenarios pin the model with literal expectations, then randomized
//   traffic runs against the model.
module tb_tqvp_prism_cfg_seq;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 4;
    localparam int GAP    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tqvp_prism_cfg_seq_if #(.DEPTH(DEPTH)) bus ();

    tqvp_prism_cfg_seq #(
        .DEPTH (DEPTH),
        .SETTLE(SETTLE),
        .GAP   (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } entry_t;

    entry_t      q[$];
    bit          m_valid = 0;
    bit          m_run   = 0;
    int          m_t     = 0;     // cycles since the run began
    int          m_prev  = 0;     // queue size during the previous cycle
    logic        m_reset = 0, m_enable = 0, m_done = 0, m_err = 0;
    logic [5:0]  m_last_a = '0;
    logic [31:0] m_last_d = '0;

    logic        corrupt   = 1'b0;
    logic [31:0] rb_shadow = '0;
    assign bus.dbg_rdata = corrupt ? 32'h0 : rb_shadow;

    int   u_sz, u_k, c_k;
    bit   u_fl, u_dn, u_rbf;
    logic        e_wr;
    logic [5:0]  e_a;
    logic [31:0] e_d;

    always begin
        @(negedge clk);
        rb_shadow = m_last_d;
        if (m_valid) begin
            e_wr = 1'b0; e_a = '0; e_d = '0;
            if (!m_run) begin
                e_wr = bus.host_wr; e_a = bus.host_addr; e_d = bus.host_wdata;
            end else if (m_t >= SETTLE) begin
                c_k = (m_t - SETTLE) % (GAP + 1);
                if (c_k == 0 && m_prev > 0 && q.size() > 0) begin
                    e_wr = 1'b1; e_a = q[0].a; e_d = q[0].d;
                end
`ifdef PRISM_CFG_READBACK_EN
                else if (c_k == 1) e_a = m_last_a;
`endif
            end
            check("dbg_wr",       64'(bus.dbg_wr),       64'(e_wr));
            check("dbg_addr",     64'(bus.dbg_addr),     64'(e_a));
            check("dbg_wdata",    64'(bus.dbg_wdata),    64'(e_d));
            check("busy",         64'(bus.busy),         64'(m_run));
            check("host_grant",   64'(bus.host_grant),   64'(!m_run));
            check("prism_reset",  64'(bus.prism_reset),  64'(m_reset));
            check("prism_enable", 64'(bus.prism_enable), 64'(m_enable));
            check("done",         64'(bus.done),         64'(m_done));
            check("err",          64'(bus.err),          64'(m_err));
            check("fill",         64'(bus.fill),         64'(q.size()));
            check("push_ready",   64'(bus.push_ready),   64'(q.size() < DEPTH));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_run = 0; m_t = 0; m_prev = 0;
            m_reset = 0; m_enable = 0; m_done = 0; m_err = 0;
            m_last_a = '0; m_last_d = '0;
            m_valid = 1;
        end else begin
            u_sz = q.size(); u_fl = 0; u_dn = 0; u_rbf = 0;
            if (m_run) begin
                u_k = (m_t >= SETTLE) ? (m_t - SETTLE) % (GAP + 1) : -1;
`ifdef PRISM_CFG_READBACK_EN
                u_rbf = (u_k == 1) && (bus.dbg_rdata !== m_last_d);
`endif
                if (bus.abort || u_rbf) begin
                    u_fl = 1; m_run = 0; m_err = 1; m_reset = 1; m_enable = 0;
                end else begin
                    if (u_k == 0 && m_prev > 0) begin
                        m_last_a = q[0].a; m_last_d = q[0].d;
                        void'(q.pop_front());
                    end else if (u_k == 0) begin
                        m_run = 0; u_dn = 1;
                    end
                    m_t++;
                    // Next cycle is a slot with nothing queued now: release.
                    if (m_run && m_t > SETTLE && (m_t - SETTLE) % (GAP + 1) == 0 && u_sz == 0) begin
                        m_reset = 0; m_enable = 1;
                    end
                end
            end else if (bus.abort) begin
                u_fl = 1;
            end else if (bus.start) begin
                m_err = 0;
                if (u_sz == 0) u_dn = 1;
                else begin
                    m_run = 1; m_t = 0; m_reset = 1; m_enable = 0;
                end
            end
            if (u_fl) q.delete();
            else if (bus.push_valid && u_sz < DEPTH) q.push_back({bus.push_addr, bus.push_data});
            m_prev = u_sz;
            m_done = u_dn;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.push_valid = 0; bus.push_addr = '0; bus.push_data = '0;
        bus.start = 0; bus.abort = 0;
        bus.host_wr = 0; bus.host_addr = '0; bus.host_wdata = '0;
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        bus.push_valid = 1; bus.push_addr = a; bus.push_data = d;
        tick();
        bus.push_valid = 0;
    endtask

    task automatic start_pulse();
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    int          wr_cyc[$];
    logic [5:0]  wr_a[$];
    logic [31:0] wr_d[$];
    int          rst_cyc, done_cyc, en_cyc, leak, grant_lo;

    // Watches a run cycle by cycle until done or the cycle budget runs out.
    task automatic observe(input int max_c);
        wr_cyc.delete(); wr_a.delete(); wr_d.delete();
        rst_cyc = 0; done_cyc = -1; en_cyc = -1; leak = 0; grant_lo = 0;
        #1;
        for (int c = 0; c < max_c; c++) begin
            if (bus.dbg_wr && !bus.host_grant) begin
                wr_cyc.push_back(c); wr_a.push_back(bus.dbg_addr); wr_d.push_back(bus.dbg_wdata);
                if (bus.dbg_addr == 6'h10) leak++;
            end
            if (bus.prism_reset && wr_cyc.size() == 0) rst_cyc++;
            if (bus.prism_enable && en_cyc < 0) en_cyc = c;
            if (!bus.host_grant) grant_lo++;
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        if (done_cyc < 0) check("run_timeout", 64'(done_cyc), 64'(0));
    endtask

    int n2;
    bit seen_done;

    initial begin
        quiet();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();

        // reset values
        check("rst_push_ready", 64'(bus.push_ready),   64'd1);
        check("rst_host_grant", 64'(bus.host_grant),   64'd1);
        check("rst_fill",       64'(bus.fill),         64'd0);
        check("rst_busy",       64'(bus.busy),         64'd0);
        check("rst_prism_rst",  64'(bus.prism_reset),  64'd0);
        check("rst_prism_en",   64'(bus.prism_enable), 64'd0);
        check("rst_err",        64'(bus.err),          64'd0);

        // 1: two-entry run
        push(6'h04, 32'hDEADBEEF);
        push(6'h08, 32'h12345678);
        start_pulse();
        observe(60);
        check("t1_settle_cycles", 64'(rst_cyc), 64'd4);
        check("t1_wr_count", 64'(wr_cyc.size()), 64'd2);
        if (wr_cyc.size() == 2) begin
            check("t1_addr0", 64'(wr_a[0]), 64'h04);
            check("t1_data0", 64'(wr_d[0]), 64'hDEADBEEF);
            check("t1_addr1", 64'(wr_a[1]), 64'h08);
            check("t1_data1", 64'(wr_d[1]), 64'h12345678);
            check("t1_first_wr_cycle", 64'(wr_cyc[0]), 64'd4);
            check("t1_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd3);
            check("t1_enable_cycle", 64'(en_cyc), 64'(wr_cyc[1] + 3));
            check("t1_done_cycle", 64'(done_cyc), 64'(wr_cyc[1] + 4));
        end
        check("t1_fill", 64'(bus.fill), 64'd0);
        check("t1_prism_en", 64'(bus.prism_enable), 64'd1);
        check("t1_prism_rst", 64'(bus.prism_reset), 64'd0);
        tick();
        check("t1_done_one_cycle", 64'(bus.done), 64'd0);
        check("t1_enable_holds", 64'(bus.prism_enable), 64'd1);

        // 2: overfill
        for (int i = 0; i < 9; i++) begin
            bus.push_valid = 1; bus.push_addr = 6'(i + 1); bus.push_data = 32'h100 + i;
            tick();
        end
        bus.push_valid = 0;
        check("t2_fill_full", 64'(bus.fill), 64'd8);
        check("t2_push_ready", 64'(bus.push_ready), 64'd0);
        start_pulse();
        observe(200);
        check("t2_wr_count", 64'(wr_cyc.size()), 64'd8);
        if (wr_cyc.size() == 8) check("t2_last_data", 64'(wr_d[7]), 64'h107);
        tick();

        // 3: host writes while sequencer owns the port, then in IDLE
        push(6'h01, 32'h11);
        push(6'h02, 32'h22);
        start_pulse();
        bus.host_wr = 1; bus.host_addr = 6'h10; bus.host_wdata = 32'hA5;
        observe(60);
        check("t3_host_leak", 64'(leak), 64'd0);
        check("t3_seq_writes", 64'(wr_cyc.size()), 64'd2);
        check("t3_grant_low_cycles", 64'(grant_lo), 64'd11);
        check("t3_idle_grant", 64'(bus.host_grant), 64'd1);
        check("t3_idle_wr", 64'(bus.dbg_wr), 64'd1);
        check("t3_idle_addr", 64'(bus.dbg_addr), 64'h10);
        check("t3_idle_data", 64'(bus.dbg_wdata), 64'hA5);
        bus.host_wr = 0;
        tick();

        // 4: abort in the second gap
        push(6'h03, 32'h33);
        push(6'h05, 32'h55);
        push(6'h06, 32'h66);
        start_pulse();
        n2 = 0;
        for (int c = 0; c < 50 && n2 < 2; c++) begin
            if (bus.dbg_wr && !bus.host_grant) n2++;
            if (n2 < 2) tick();
        end
        check("t4_second_write", 64'(n2), 64'd2);
        tick();
        bus.abort = 1;
        tick();
        bus.abort = 0;
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_fill", 64'(bus.fill), 64'd0);
        check("t4_err", 64'(bus.err), 64'd1);
        check("t4_prism_rst", 64'(bus.prism_reset), 64'd1);
        check("t4_prism_en", 64'(bus.prism_enable), 64'd0);
        check("t4_no_done", 64'(bus.done), 64'd0);
        push(6'h07, 32'h77);
        start_pulse();
        check("t4_err_cleared", 64'(bus.err), 64'd0);
        check("t4_restart_busy", 64'(bus.busy), 64'd1);
        observe(60);
        tick();

        // 5: empty start, then start+abort together
        start_pulse();
        check("t5_done", 64'(bus.done), 64'd1);
        check("t5_no_reset", 64'(bus.prism_reset), 64'd0);
        check("t5_idle", 64'(bus.busy), 64'd0);
        tick();
        check("t5_done_pulse", 64'(bus.done), 64'd0);
        push(6'h09, 32'h99);
        bus.start = 1; bus.abort = 1;
        tick();
        bus.start = 0; bus.abort = 0;
        check("t5_abort_wins_busy", 64'(bus.busy), 64'd0);
        check("t5_abort_wins_fill", 64'(bus.fill), 64'd0);
        check("t5_abort_wins_done", 64'(bus.done), 64'd0);
        check("t5_abort_wins_rst", 64'(bus.prism_reset), 64'd0);

`ifdef PRISM_CFG_READBACK_EN
        // 6: readback mismatch
        push(6'h01, 32'h1);
        corrupt = 1;
        start_pulse();
        seen_done = 0;
        for (int c = 0; c < 40 && bus.busy; c++) begin
            tick();
            if (bus.done) seen_done = 1;
        end
        corrupt = 0;
        check("t6_err", 64'(bus.err), 64'd1);
        check("t6_no_done", 64'(seen_done), 64'd0);
        check("t6_prism_rst", 64'(bus.prism_reset), 64'd1);
        check("t6_prism_en", 64'(bus.prism_enable), 64'd0);
        check("t6_fill", 64'(bus.fill), 64'd0);
`endif

        // rst mid-sequence
        push(6'h0A, 32'hAA);
        push(6'h0B, 32'hBB);
        start_pulse();
        repeat (5) tick();
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_fill", 64'(bus.fill), 64'd0);
        check("mid_rst_prism_rst", 64'(bus.prism_reset), 64'd0);
        check("mid_rst_prism_en", 64'(bus.prism_enable), 64'd0);
        check("mid_rst_err", 64'(bus.err), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.push_valid = ($urandom_range(0, 2) == 0);
            bus.push_addr  = 6'($urandom);
            bus.push_data  = $urandom;
            bus.start      = ($urandom_range(0, 30) == 0);
            bus.abort      = ($urandom_range(0, 150) == 0);
            bus.host_wr    = ($urandom_range(0, 3) == 0);
            bus.host_addr  = 6'($urandom);
            bus.host_wdata = $urandom;
            corrupt        = ($urandom_range(0, 40) == 0);
            rst            = ($urandom_range(0, 800) == 0);
            tick();
        end
        quiet();
        corrupt = 0;
        rst = 0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
